// File: rtl/axi4_lite_master_seq.sv
// -----------------------------------------------------------------------------
// axi4_lite_master_seq
//
// Turns single-beat read/write commands from a simple command port into
// AXI4-Lite master transactions. Exactly one transaction is in flight at a
// time, each command produces exactly one response pulse, and every
// transaction is bounded by a cycle timeout.
//
// Handshake semantics (all channels, command port included): a transfer
// happens on a rising clock edge where valid && ready are both high. A valid
// never waits for ready before asserting, and once asserted it stays high
// with its payload stable until the transfer. rsp_valid is a single-cycle
// pulse with no backpressure.
//
// Ports
//   clock, reset_n           rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake (cmd_ready is registered)
//   cmd_write                1 = write, 0 = read
//   cmd_addr/wdata/wstrb     command payload, latched on accept
//   rsp_valid                one-cycle response pulse
//   rsp_rdata                read data (0 for writes and timeouts)
//   rsp_resp                 captured BRESP/RRESP, 2'b10 on timeout
//   rsp_timeout              transaction aborted by the timeout
//   aw*/w*/b*/ar*/r*         AXI4-Lite master channels
//   state_dbg                current FSM state encoding, for observation
// -----------------------------------------------------------------------------
module axi4_lite_master_seq #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clock,
   input  logic                    reset_n,
   // command port
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   // response port
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    rsp_timeout,
   // AW channel
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic [2:0]              awprot,
   output logic                    awvalid,
   input  logic                    awready,
   // W channel
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wvalid,
   input  logic                    wready,
   // B channel
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready,
   // AR channel
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic [2:0]              arprot,
   output logic                    arvalid,
   input  logic                    arready,
   // R channel
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp,
   input  logic                    rvalid,
   output logic                    rready,
   // observation
   output logic [2:0]              state_dbg
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   // Counter is wide enough to hold TIMEOUT_CYCLES itself so it can saturate
   // there instead of wrapping.
   localparam int CNT_WIDTH = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST =
      CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(TIMEOUT_CYCLES);

   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t state;
   state_t state_next;

   // Latched command payload, held for the whole transaction.
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;

   // AW and W complete independently; these remember which one is finished.
   logic aw_done;
   logic w_done;

   logic [CNT_WIDTH-1:0] tcnt;

   logic accept;
   logic busy;
   logic expired;
   logic aw_hs;
   logic w_hs;
   logic ar_hs;
   logic aw_ok;
   logic w_ok;
   logic cap_b;
   logic cap_r;
   logic abort;

   // ---------------------------------------------------------------------------
   // Channel outputs decoded from state; an asynchronous reset of the state
   // register therefore drops every valid/ready immediately.
   // ---------------------------------------------------------------------------
   assign awvalid   = (state == WR_REQ) && !aw_done;
   assign wvalid    = (state == WR_REQ) && !w_done;
   assign bready    = (state == WR_RESP);
   assign arvalid   = (state == RD_REQ);
   assign rready    = (state == RD_RESP);
   assign rsp_valid = (state == DONE);

   assign awaddr = addr_q;
   assign araddr = addr_q;
   assign wdata  = wdata_q;
   assign wstrb  = wstrb_q;
   assign awprot = 3'b000;
   assign arprot = 3'b000;

   assign state_dbg = state;

   assign accept = (state == IDLE) && cmd_valid && cmd_ready;
   assign busy   = (state == WR_REQ) || (state == WR_RESP) ||
                   (state == RD_REQ) || (state == RD_RESP);

   // Once the counter reaches its last slot the transaction stays expired;
   // a handshake that completes the current phase still wins in that cycle.
   assign expired = TIMEOUT_EN && (tcnt >= CNT_LAST);

   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;
   assign ar_hs = arvalid && arready;
   assign aw_ok = aw_done || aw_hs;
   assign w_ok  = w_done || w_hs;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      cap_b      = 1'b0;
      cap_r      = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = cmd_write ? WR_REQ : RD_REQ;
            end
         end
         WR_REQ: begin
            if (aw_ok && w_ok) begin
               state_next = WR_RESP;
            end else if (expired) begin
               state_next = DONE;
               abort      = 1'b1;
            end
         end
         WR_RESP: begin
            if (bvalid) begin
               state_next = DONE;
               cap_b      = 1'b1;
            end else if (expired) begin
               state_next = DONE;
               abort      = 1'b1;
            end
         end
         RD_REQ: begin
            if (ar_hs) begin
               state_next = RD_RESP;
            end else if (expired) begin
               state_next = DONE;
               abort      = 1'b1;
            end
         end
         RD_RESP: begin
            if (rvalid) begin
               state_next = DONE;
               cap_r      = 1'b1;
            end else if (expired) begin
               state_next = DONE;
               abort      = 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         cmd_ready   <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         tcnt        <= '0;
         rsp_rdata   <= '0;
         rsp_resp    <= 2'b00;
         rsp_timeout <= 1'b0;
      end else begin
         state <= state_next;
         // Registered ready: high exactly when the FSM will sit in IDLE, so it
         // first rises one edge after reset release and one cycle after DONE.
         cmd_ready <= (state_next == IDLE);

         if (accept) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            tcnt    <= '0;
         end else begin
            if (aw_hs) begin
               aw_done <= 1'b1;
            end
            if (w_hs) begin
               w_done <= 1'b1;
            end
            if (busy && (tcnt != CNT_MAX)) begin
               tcnt <= tcnt + 1'b1;
            end
         end

         if (cap_b) begin
            rsp_rdata   <= '0;
            rsp_resp    <= bresp;
            rsp_timeout <= 1'b0;
         end else if (cap_r) begin
            rsp_rdata   <= rdata;
            rsp_resp    <= rresp;
            rsp_timeout <= 1'b0;
         end else if (abort) begin
            rsp_rdata   <= '0;
            rsp_resp    <= RESP_SLVERR;
            rsp_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axi4_lite_master_seq.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_master_seq
//
// Drives commands into axi4_lite_master_seq against a behavioural AXI4-Lite
// slave whose per-transaction delays and responses are chosen up front. The
// expected response (data, resp, timeout flag and the cycle it must appear)
// is derived from those choices with plain arithmetic and queued at accept;
// a monitor pops and compares on every rsp_valid.
// -----------------------------------------------------------------------------
module tb_axi4_lite_master_seq;

   localparam int TO = 16;
   localparam int EW = 16 + 1 + 2 + 32;   // {cycle, timeout, resp, rdata}

   // ---------------------------------------------------------------- signals
   logic        clock;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        rsp_timeout;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready = 1'b0;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready = 1'b0;
   logic [1:0]  bresp = 2'b00;
   logic        bvalid = 1'b0;
   logic        bready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready = 1'b0;
   logic [31:0] rdata = 32'h0;
   logic [1:0]  rresp = 2'b00;
   logic        rvalid = 1'b0;
   logic        rready;
   logic [2:0]  state_dbg;

   axi4_lite_master_seq #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .cmd_wstrb   (cmd_wstrb),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_resp    (rsp_resp),
      .rsp_timeout (rsp_timeout),
      .awaddr      (awaddr),
      .awprot      (awprot),
      .awvalid     (awvalid),
      .awready     (awready),
      .wdata       (wdata),
      .wstrb       (wstrb),
      .wvalid      (wvalid),
      .wready      (wready),
      .bresp       (bresp),
      .bvalid      (bvalid),
      .bready      (bready),
      .araddr      (araddr),
      .arprot      (arprot),
      .arvalid     (arvalid),
      .arready     (arready),
      .rdata       (rdata),
      .rresp       (rresp),
      .rvalid      (rvalid),
      .rready      (rready),
      .state_dbg   (state_dbg)
   );

   // ---------------------------------------------------------- clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog actual=time_expired required=finish");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------- bookkeeping
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          daw, dw, db;   // write: cycles of AW/W valid before ready, cycles before bvalid
      int          dar, dr;       // read:  cycles of AR valid before ready, cycles before rvalid
      logic [1:0]  resp;
      logic [31:0] rdata;
   } plan_t;

   plan_t       plan_q[$];
   logic [EW-1:0] exp_q[$];

   function automatic plan_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [3:0] ws, input int d0, input int d1, input int d2,
                                input logic [1:0] resp, input logic [31:0] rd);
      plan_t p;
      p.wr = wr; p.addr = addr; p.wdata = wd; p.wstrb = ws;
      p.daw = wr ? d0 : 0; p.dw = wr ? d1 : 0; p.db = wr ? d2 : 0;
      p.dar = wr ? 0 : d0; p.dr = wr ? 0 : d1;
      p.resp = resp; p.rdata = rd;
      return p;
   endfunction

   function automatic int rand_delay();
      return ($urandom_range(0, 11) == 0) ? 20 : int'($urandom_range(0, 3));
   endfunction

   function automatic plan_t rand_plan();
      return mk(bit'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
                4'($urandom_range(0, 15)), rand_delay(), rand_delay(), rand_delay(),
                2'($urandom_range(0, 3)), $urandom);
   endfunction

   // Reference model. Cycle 0 is the accept cycle. The request phase finishes
   // with its last handshake in cycle r, the response handshake lands in
   // cycle c, and the response pulse follows one cycle later. From cycle TO
   // on the transaction is expired: each cycle must complete the phase in
   // progress or the transaction aborts, with the pulse the cycle after.
   function automatic logic [EW-1:0] expect_rsp(input plan_t p, input int k);
      int r, c, lim, t;
      if (p.wr) begin
         r = 1 + ((p.daw > p.dw) ? p.daw : p.dw);
         c = r + 1 + p.db;
      end else begin
         r = 1 + p.dar;
         c = r + 1 + p.dr;
      end
      lim = (r + 1 > TO) ? r + 1 : TO;
      if (r <= TO && c <= lim)
         return {16'(k + c + 1), 1'b0, p.resp, (p.wr ? 32'h0 : p.rdata)};
      t = (r > TO) ? TO : lim;
      return {16'(k + t + 1), 1'b1, 2'b10, 32'h0};
   endfunction

   // ---------------------------------------------------------------- monitor
   bit chk_ready_next = 1'b0;

   always @(negedge clock) begin
      logic [EW-1:0] e;
      if (!reset_n) begin
         chk_ready_next = 1'b0;
      end else begin
         if (chk_ready_next) begin
            chk("cmd_ready_after_rsp", 64'(cmd_ready), 64'(1));
            chk_ready_next = 1'b0;
         end
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
            end else begin
               e = exp_q.pop_front();
               chk("rsp_cycle",   64'(cyc),         64'(e[50:35]));
               chk("rsp_timeout", 64'(rsp_timeout), 64'(e[34]));
               chk("rsp_resp",    64'(rsp_resp),    64'(e[33:32]));
               chk("rsp_rdata",   64'(rsp_rdata),   64'(e[31:0]));
               chk("cmd_ready_during_rsp", 64'(cmd_ready), 64'(0));
               chk_ready_next = 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------ slave
   bit    s_active = 1'b0;
   bit    spur = 1'b0;
   plan_t pl;
   bit    aw_done_s, w_done_s, ar_done_s;
   bit    aw_fire, w_fire, ar_fire;
   int    aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;

   always @(negedge clock) begin
      if (!reset_n) begin
         s_active = 1'b0;
         aw_fire = 1'b0; w_fire = 1'b0; ar_fire = 1'b0;
         awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
         arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
      end else begin
         if (rsp_valid) s_active = 1'b0;
         if (s_active) begin
            if (aw_fire) aw_done_s = 1'b1;
            if (w_fire)  w_done_s  = 1'b1;
            if (ar_fire) ar_done_s = 1'b1;
         end
         aw_fire = 1'b0; w_fire = 1'b0; ar_fire = 1'b0;
         awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
         arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;

         if (!s_active && (awvalid || wvalid || arvalid)) begin
            if (plan_q.size() == 0) begin
               chk("valid_without_cmd", 64'({awvalid, wvalid, arvalid}), 64'(0));
            end else begin
               pl = plan_q.pop_front();
               s_active = 1'b1;
               aw_done_s = 1'b0; w_done_s = 1'b0; ar_done_s = 1'b0;
               aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            end
         end

         if (s_active && pl.wr) begin
            chk("arvalid_in_write", 64'(arvalid), 64'(0));
            if (awvalid) begin
               chk("awvalid_after_hs", 64'(aw_done_s), 64'(0));
               chk("awaddr", 64'(awaddr), 64'(pl.addr));
               chk("awprot", 64'(awprot), 64'(0));
               awready = !aw_done_s && (aw_cnt >= pl.daw);
               aw_fire = awready;
               aw_cnt++;
            end
            if (wvalid) begin
               chk("wvalid_after_hs", 64'(w_done_s), 64'(0));
               chk("wdata", 64'(wdata), 64'(pl.wdata));
               chk("wstrb", 64'(wstrb), 64'(pl.wstrb));
               wready = !w_done_s && (w_cnt >= pl.dw);
               w_fire = wready;
               w_cnt++;
            end
            if (aw_done_s && w_done_s) begin
               bvalid = (b_cnt >= pl.db);
               bresp  = pl.resp;
               b_cnt++;
            end
         end else if (s_active) begin
            chk("aw_w_valid_in_read", 64'({awvalid, wvalid}), 64'(0));
            if (arvalid) begin
               chk("arvalid_after_hs", 64'(ar_done_s), 64'(0));
               chk("araddr", 64'(araddr), 64'(pl.addr));
               chk("arprot", 64'(arprot), 64'(0));
               arready = !ar_done_s && (ar_cnt >= pl.dar);
               ar_fire = arready;
               ar_cnt++;
            end
            if (ar_done_s) begin
               rvalid = (r_cnt >= pl.dr);
               rdata  = rvalid ? pl.rdata : 32'h0;
               rresp  = pl.resp;
               r_cnt++;
            end
         end else if (spur) begin
            // Stray responses while no transaction is open must be ignored.
            bvalid = 1'b1; bresp = 2'b01;
            rvalid = 1'b1; rresp = 2'b01; rdata = $urandom;
         end
      end
   end

   // ---------------------------------------------------------------- driver
   task automatic issue(input plan_t p, input bit hold);
      int w = 0;
      bit acc = 1'b0;
      cmd_valid = 1'b1;
      cmd_write = p.wr;
      cmd_addr  = p.addr;
      cmd_wdata = p.wdata;
      cmd_wstrb = p.wstrb;
      while (!acc && w < 100) begin
         if (cmd_ready) acc = 1'b1;
         else begin
            @(negedge clock);
            w++;
         end
      end
      chk("cmd_accepted", 64'(acc), 64'(1));
      if (acc) begin
         plan_q.push_back(p);
         exp_q.push_back(expect_rsp(p, cyc));
      end
      @(negedge clock);
      if (!hold || !acc) cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clock);
         n++;
      end
      chk("drain_pending", 64'(exp_q.size()), 64'(0));
      @(negedge clock);
   endtask

   // ------------------------------------------------------------------- main
   initial begin
      int n;
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 32'h0;
      cmd_wdata = 32'h0;
      cmd_wstrb = 4'h0;
      repeat (3) @(negedge clock);

      // Reset state
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
      chk("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 64'(0));
      chk("rst_rsp", 64'({rsp_timeout, rsp_resp, rsp_rdata}), 64'(0));
      chk("rst_payload", 64'({awaddr, wdata}), 64'(0));
      chk("rst_state", 64'(state_dbg), 64'(0));
      reset_n = 1'b1;
      #1 chk("cmd_ready_before_edge", 64'(cmd_ready), 64'(0));
      @(negedge clock);
      chk("cmd_ready_after_release", 64'(cmd_ready), 64'(1));

      // Minimum-latency write, then read with a slow R channel
      issue(mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0), 1'b0);
      drain();
      issue(mk(1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, 5, 0, 2'b00, 32'h1234_5678), 1'b0);
      drain();

      // AW delayed three cycles, W immediate
      issue(mk(1'b1, 32'h0000_0044, 32'hCAFE_F00D, 4'h5, 3, 0, 0, 2'b00, 32'h0), 1'b0);
      drain();

      // AR never ready: timeout, then the next command must still be taken
      issue(mk(1'b0, 32'h0000_0080, 32'h0, 4'h0, 1000, 0, 0, 2'b00, 32'hFFFF_FFFF), 1'b0);
      drain();
      issue(mk(1'b1, 32'h0000_0084, 32'h0102_0304, 4'h3, 0, 1, 0, 2'b01, 32'h0), 1'b0);
      drain();

      // Timeout boundary: R handshake exactly at expiry wins; one later loses
      issue(mk(1'b0, 32'h0000_00A0, 32'h0, 4'h0, 13, 1, 0, 2'b00, 32'hA5A5_0001), 1'b0);
      drain();
      issue(mk(1'b0, 32'h0000_00A4, 32'h0, 4'h0, 14, 1, 0, 2'b00, 32'hA5A5_0002), 1'b0);
      drain();
      // Write stuck in the response phase
      issue(mk(1'b1, 32'h0000_00A8, 32'h5555_AAAA, 4'hF, 1, 2, 30, 2'b00, 32'h0), 1'b0);
      drain();

      // Stray B/R responses while idle
      spur = 1'b1;
      repeat (4) @(negedge clock);
      spur = 1'b0;
      @(negedge clock);
      chk("idle_after_stray", 64'({cmd_ready, state_dbg}), 64'({1'b1, 3'd0}));

      // Reset pulsed during the write response phase
      issue(mk(1'b1, 32'h0000_00C0, 32'h1111_2222, 4'hF, 0, 0, 10, 2'b00, 32'h0), 1'b0);
      n = 0;
      while (!bready && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk("reached_wr_resp", 64'(bready), 64'(1));
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_bready", 64'(bready), 64'(0));
      chk("midrst_outputs", 64'({awvalid, wvalid, arvalid, rready, rsp_valid, cmd_ready}), 64'(0));
      exp_q.delete();
      plan_q.delete();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      #1 chk("midrst_ready_low", 64'(cmd_ready), 64'(0));
      @(negedge clock);
      chk("midrst_ready_high", 64'(cmd_ready), 64'(1));
      repeat (2) @(negedge clock);

      // Back-to-back randomized commands with cmd_valid held high
      for (int i = 0; i < 60; i++) begin
         issue(rand_plan(), 1'b1);
      end
      cmd_valid = 1'b0;
      drain();
      issue(mk(1'b1, 32'h0000_0100, 32'h0BAD_0BAD, 4'h9, 0, 0, 0, 2'b10, 32'h0), 1'b1);
      issue(mk(1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, 0, 0, 2'b10, 32'h7777_8888), 1'b0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
